rggen_bit_field_rc_event_counter: RTL
=====================================

// Module: rggen_bit_field_rc_event_counter
// PURPOSE
//  Read-to-clear hardware event counter bit field for generated register blocks.
//  - Hardware side adds an increment into the field; the field saturates or wraps.
//  - Software side reads the count; the read atomically clears the field.
//  - Increments arriving in the read cycle are kept, never lost.
//  - Sticky o_overflow reports lost or wrapped counts; it is cleared by the same read.
// PARAMETERS
//  WIDTH          8  counter width; legal range 1..32
//  INC_WIDTH      1  increment width; must be <= WIDTH
//  INITIAL_VALUE  0  counter value at reset and after i_clear
//  SATURATE       1  1: clamp at all-ones; 0: wrap modulo 2**WIDTH
// PORTS
//  clk                input   1          clock; every flop is rising-edge
//  rst_n              input   1          asynchronous reset, active-low
//  i_enable           input   1          counting enable (from a control field)
//  i_increment_valid  input   1          increment qualifier for this cycle
//  i_increment        input   INC_WIDTH  unsigned amount to add
//  i_clear            input   1          synchronous hardware clear
//  i_command_valid    input   1          bus command valid
//  i_select           input   1          this register is addressed
//  i_write            input   1          1 = write, 0 = read
//  o_read_data        output  WIDTH      current count (read data lane)
//  o_value            output  WIDTH      current count (to hardware)
//  o_overflow         output  1          sticky overflow flag
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): count = INITIAL_VALUE; o_overflow = 0.
//  - Read outputs: o_read_data = o_value = count register. Combinational from the flop,
//    so the read returns the pre-clear value in the access cycle.
//  - rd = i_command_valid & i_select & !i_write.
//  - Writes (i_write = 1) have no effect on the field.
//  - inc = (i_enable & i_increment_valid) ? zero_ext(i_increment) : 0.
//  - Sum is computed WIDTH+1 bits wide: sum = base + inc.
//    - base = rd ? 0 : count.
//    - carry = sum[WIDTH].
//  - Next count:
//    - if carry == 0: sum[WIDTH-1:0].
//    - if carry == 1: SATURATE ? all-ones : sum[WIDTH-1:0].
//  - Next o_overflow = (rd ? 0 : o_overflow) | carry.
//  - Priority: i_clear > read-clear > increment.
//    - i_clear forces count = INITIAL_VALUE and o_overflow = 0.
//    - A concurrent increment is discarded.
//  - Saturation holds: once at all-ones, every further nonzero inc sets overflow and keeps all-ones.
//  - A zero increment never sets overflow.
//  - Read and increment in the same cycle: read returns the old count; next count = inc.
//  - Latency: 1 cycle from increment to visible count. A read clears on the next edge.
//  - Reset asserted mid-access: state returns to reset values immediately; the access is dropped.
// STRUCTURE
//  - Use the is_read_access helper from rggen_bit_field_common.svh.
//  - Elaboration-time checks belong in the same shared include:
//    - INC_WIDTH <= WIDTH;
//    - INITIAL_VALUE fits in WIDTH.
//  - Sub-module rggen_bit_field_sat_adder (WIDTH, INC_WIDTH, SATURATE):
//    - inputs: base, inc;
//    - outputs: next value, carry.
//  - Top level holds the clear/priority mux, the count flop and the sticky flag flop.
// TESTING
//  - Reset and increment:
//    - WIDTH=8, INITIAL_VALUE=5: reset -> o_value = 5, o_overflow = 0.
//    - Three cycles of inc = 1 -> o_value = 8.
//  - Read-clear with concurrent event:
//    - count = 0x20; rd cycle with inc = 1 -> o_read_data = 0x20 that cycle.
//    - Next cycle o_value = 1.
//  - Saturation (SATURATE=1, WIDTH=4, INC_WIDTH=2):
//    - count = 14, inc = 3 -> count = 15, o_overflow = 1.
//    - Further inc -> stays 15.
//    - Then rd -> count = 0, o_overflow = 0.
//  - Wrap (SATURATE=0, WIDTH=4):
//    - count = 15, inc = 1 -> count = 0, o_overflow = 1.
//    - A write access (i_write = 1) -> no change.
//  - Priority and gating:
//    - i_clear with rd and inc = 1 -> count = INITIAL_VALUE.
//    - i_enable = 0 with i_increment_valid = 1 -> count unchanged.
//  - Async reset mid-run: drop rst_n between clock edges -> outputs go to reset values immediately.

Source files
------------

// File: rtl/rggen_bit_field_rc_event_counter_pkg.sv
// Shared definitions for the read-to-clear event counter bit field:
// the read-access qualifier, the update-priority encoding and parameter checks.
package rggen_bit_field_rc_event_counter_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 32;

  // What the field does on the coming edge, highest priority first.
  typedef enum logic [1:0] {
    ACTION_CLEAR      = 2'd0,
    ACTION_READ_CLEAR = 2'd1,
    ACTION_COUNT      = 2'd2
  } rc_action_e;

  function automatic logic is_read_access(
    input logic command_valid,
    input logic select,
    input logic write
  );
    return command_valid & select & ~write;
  endfunction

  function automatic bit width_is_legal(input int width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

  function automatic bit value_fits(input int width, input longint unsigned value);
    return (value >> width) == 64'd0;
  endfunction

  function automatic rc_action_e decode_action(input logic clear, input logic read);
    rc_action_e action;
    action = ACTION_COUNT;
    if (clear) begin
      action = ACTION_CLEAR;
    end else if (read) begin
      action = ACTION_READ_CLEAR;
    end
    return action;
  endfunction

endpackage

// File: rtl/rggen_bit_field_sat_adder.sv
// Adds an unsigned increment to a base value one bit wider than the field,
// then either clamps to all-ones or wraps when the sum carries out.
module rggen_bit_field_sat_adder #(
  parameter int WIDTH     = 8,
  parameter int INC_WIDTH = 1,
  parameter bit SATURATE  = 1'b1
) (
  input  logic [WIDTH-1:0]     i_base,
  input  logic [INC_WIDTH-1:0] i_inc,
  output logic [WIDTH-1:0]     o_next_value,
  output logic                 o_carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] inc_ext;

  always_comb begin
    inc_ext      = {{(WIDTH + 1 - INC_WIDTH){1'b0}}, i_inc};
    sum          = {1'b0, i_base} + inc_ext;
    o_carry      = sum[WIDTH];
    o_next_value = sum[WIDTH-1:0];
    if (sum[WIDTH] && SATURATE) begin
      o_next_value = '1;
    end
  end

endmodule

// File: rtl/rggen_bit_field_rc_event_counter.sv
// Read-to-clear hardware event counter field: hardware increments, a software
// read returns the count and clears it while keeping same-cycle events.
module rggen_bit_field_rc_event_counter
  import rggen_bit_field_rc_event_counter_pkg::*;
#(
  parameter int              WIDTH         = 8,
  parameter int              INC_WIDTH     = 1,
  parameter longint unsigned INITIAL_VALUE = 0,
  parameter bit              SATURATE      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_increment_valid,
  input  logic [INC_WIDTH-1:0] i_increment,
  input  logic                 i_clear,
  input  logic                 i_command_valid,
  input  logic                 i_select,
  input  logic                 i_write,
  output logic [WIDTH-1:0]     o_read_data,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_overflow
);

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("rggen_bit_field_rc_event_counter: WIDTH must be within 1..32");
  end
  if (INC_WIDTH < 1 || INC_WIDTH > WIDTH) begin : g_bad_inc_width
    $error("rggen_bit_field_rc_event_counter: INC_WIDTH must be within 1..WIDTH");
  end
  if (!value_fits(WIDTH, INITIAL_VALUE)) begin : g_bad_initial_value
    $error("rggen_bit_field_rc_event_counter: INITIAL_VALUE does not fit in WIDTH");
  end

  localparam logic [WIDTH-1:0] INIT = INITIAL_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0]     count_q;
  logic [WIDTH-1:0]     count_d;
  logic                 overflow_q;
  logic                 overflow_d;
  logic                 read_access;
  rc_action_e           action;
  logic [INC_WIDTH-1:0] inc_gated;
  logic [WIDTH-1:0]     adder_base;
  logic [WIDTH-1:0]     adder_next;
  logic                 adder_carry;

  always_comb begin
    read_access = is_read_access(i_command_valid, i_select, i_write);
    action      = decode_action(i_clear, read_access);
    inc_gated   = (i_enable && i_increment_valid) ? i_increment : '0;
    // A read restarts the count from zero so same-cycle events survive the clear.
    adder_base  = (action == ACTION_READ_CLEAR) ? '0 : count_q;
  end

  rggen_bit_field_sat_adder #(
    .WIDTH     (WIDTH),
    .INC_WIDTH (INC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_adder (
    .i_base       (adder_base),
    .i_inc        (inc_gated),
    .o_next_value (adder_next),
    .o_carry      (adder_carry)
  );

  always_comb begin
    count_d    = adder_next;
    overflow_d = overflow_q | adder_carry;
    case (action)
      ACTION_CLEAR: begin
        count_d    = INIT;
        overflow_d = 1'b0;
      end
      ACTION_READ_CLEAR: begin
        overflow_d = adder_carry;
      end
      default: begin
        overflow_d = overflow_q | adder_carry;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= INIT;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_read_data = count_q;
  assign o_value     = count_q;
  assign o_overflow  = overflow_q;

endmodule
